fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS datapath. Owns the program counter, drives the address of the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Handles stall, flush, branch/jump redirect and halt requests from the hazard and control logic downstream.

---
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction memory address and IF/ID pipeline register.
// Optional macro FETCH_MISALIGN_CHK_EN enables the sticky misaligned-redirect flag.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_r, state_next_s;
  logic [31:0] pc_r, pc_next_s;
  logic [31:0] instr_r, instr_next_s;
  logic [31:0] pc4_r, pc4_next_s;
  logic        valid_r, valid_next_s;
  logic        halted_r, halted_next_s;
  logic        redirect_take_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;

  assign pc_plus4_s = pc_r + 32'd4;
  assign target_s   = {redirect_pc[31:2], 2'b00};

  // Next-state, next-PC and IF/ID selection; redirect outranks halt, flush and stall.
  always_comb begin
    state_next_s    = state_r;
    pc_next_s       = pc_r;
    instr_next_s    = instr_r;
    pc4_next_s      = pc4_r;
    valid_next_s    = valid_r;
    redirect_take_s = 1'b0;
    case (state_r)
      BOOT: begin
        state_next_s = RUN;
        pc_next_s    = RESET_PC;
        instr_next_s = NOP_WORD;
        pc4_next_s   = 32'd0;
        valid_next_s = 1'b0;
      end
      RUN: begin
        if (redirect_valid) begin
          redirect_take_s = 1'b1;
          pc_next_s       = target_s;
        end else if (halt_req) begin
          state_next_s = HALTED;
        end else if (stall) begin
          pc_next_s = pc_r;
        end else begin
          pc_next_s = pc_plus4_s;
        end
        if (redirect_valid || flush || halt_req) begin
          instr_next_s = NOP_WORD;
          pc4_next_s   = 32'd0;
          valid_next_s = 1'b0;
        end else if (stall) begin
          valid_next_s = valid_r;
        end else begin
          instr_next_s = imem_rdata;
          pc4_next_s   = pc_plus4_s;
          valid_next_s = 1'b1;
        end
      end
      HALTED: begin
        instr_next_s = NOP_WORD;
        pc4_next_s   = 32'd0;
        valid_next_s = 1'b0;
        if (redirect_valid) begin
          redirect_take_s = 1'b1;
          pc_next_s       = target_s;
          state_next_s    = RUN;
        end else begin
          state_next_s = HALTED;
        end
      end
      default: begin
        state_next_s = BOOT;
        pc_next_s    = RESET_PC;
        instr_next_s = NOP_WORD;
        pc4_next_s   = 32'd0;
        valid_next_s = 1'b0;
      end
    endcase
    halted_next_s = (state_next_s == HALTED);
  end

  // Pipeline state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= BOOT;
      pc_r     <= RESET_PC;
      instr_r  <= NOP_WORD;
      pc4_r    <= 32'd0;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      pc_r     <= pc_next_s;
      instr_r  <= instr_next_s;
      pc4_r    <= pc4_next_s;
      valid_r  <= valid_next_s;
      halted_r <= halted_next_s;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_r;

  // Sticky flag: any taken redirect with nonzero low address bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= misalign_r | (redirect_take_s & (redirect_pc[1:0] != 2'b00));
    end
  end

  assign misalign_err = misalign_r;
`else
  logic unused_misalign_inputs;

  // Low redirect bits are silently dropped in this build.
  assign unused_misalign_inputs = redirect_take_s ^ redirect_pc[1] ^ redirect_pc[0];
  assign misalign_err           = 1'b0;
`endif

  assign imem_addr      = pc_r;
  assign pc             = pc_r;
  assign if_id_instr    = instr_r;
  assign if_id_pc_plus4 = pc4_r;
  assign if_id_valid    = valid_r;
  assign halted         = halted_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven self-checking bench for fetch_stage with a combinational instruction-memory model.
module tb_fetch_stage;

  localparam logic [31:0] W0 = 32'h2008_0005;
  localparam logic [31:0] W1 = 32'h2009_0003;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic MIS_ON = 1'b1;
`else
  localparam logic MIS_ON = 1'b0;
`endif

  logic        clk, reset, stall, flush, redirect_valid, halt_req;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, pc;
  logic [31:0] if_id_instr, if_id_pc_plus4;
  logic        if_id_valid, halted, misalign_err;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .halted(halted), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return W0;
    else if (a == 32'h4) return W1;
    else return {16'hC0DE, a[15:0]};
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic        st, fl, rv;
    logic [31:0] rpc;
    logic        hr;
    logic [31:0] e_pc, e_instr, e_p4;
    logic        e_v, e_h, e_m;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic [31:0] e_p4, input logic e_v, input logic e_h, input logic e_m);
    chk({tag, "_pc"}, pc, e_pc);
    chk({tag, "_addr"}, imem_addr, e_pc);
    chk({tag, "_instr"}, if_id_instr, e_instr);
    chk({tag, "_p4"}, if_id_pc_plus4, e_p4);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, e_v});
    chk({tag, "_halted"}, {31'd0, halted}, {31'd0, e_h});
    chk({tag, "_mis"}, {31'd0, misalign_err}, {31'd0, e_m});
  endtask

  initial begin
    // stall flush rv rpc halt | pc instr p4 valid halted mis
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});   // BOOT
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4, W0, 32'h4, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8, W1, 32'h8, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8, W1, 32'h8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hC, 32'hC0DE_0008, 32'hC, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h10, 32'hC0DE_000C, 32'h10, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44, 32'hC0DE_0040, 32'h44, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{i[0], ~i[0], 1'b0, 32'h0, i[1], 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4, W0, 32'h4, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hC, 32'hC0DE_0008, 32'hC, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hC0DE_FFFC, 32'h0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, MIS_ON});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44, 32'hC0DE_0040, 32'h44, 1'b1, 1'b0, MIS_ON});

    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; halt_req = 1'b0;
    #12;
    chk_all("rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      stall = vecs[i].st; flush = vecs[i].fl; redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc; halt_req = vecs[i].hr;
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_p4,
              vecs[i].e_v, vecs[i].e_h, vecs[i].e_m);
    end

    // Asynchronous reset in the middle of a cycle, then the boot sequence again.
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_all("arst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("boot2", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("first2", 32'h4, W0, 32'h4, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
